// File: rtl/axi_llc_arcane_dma_ctl.sv
// Software-DMA sequencer: copies len words src->dst over OBI read/write channels via a credit-limited FIFO.
// Optional cycle counter on cycles_o when AXI_LLC_ARCANE_DMA_PERF_EN is defined.
module axi_llc_arcane_dma_ctl #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LenWidth  = 16,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   lock_ok_i,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   src_addr_i,
  input  logic [AddrWidth-1:0]   dst_addr_i,
  input  logic [LenWidth-1:0]    len_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   rd_req_o,
  input  logic                   rd_gnt_i,
  output logic [AddrWidth-1:0]   rd_addr_o,
  input  logic                   rd_rvalid_i,
  input  logic [DataWidth-1:0]   rd_rdata_i,
  output logic                   wr_req_o,
  input  logic                   wr_gnt_i,
  output logic [AddrWidth-1:0]   wr_addr_o,
  output logic [DataWidth-1:0]   wr_wdata_o,
  output logic [DataWidth/8-1:0] wr_be_o,
  input  logic                   wr_rvalid_i
`ifdef AXI_LLC_ARCANE_DMA_PERF_EN
  , output logic [31:0]          cycles_o
`endif
);
  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned PtrW    = $clog2(FifoDepth);
  localparam int unsigned CntW    = PtrW + 1;
  localparam logic [CntW:0] DepthC = (CntW+1)'(FifoDepth);

  typedef enum logic [1:0] {IDLE, COPY, DRAIN, DONE} state_e;
  state_e state_q, state_d;

  logic [AddrWidth-1:0] src_q, dst_q;
  logic [LenWidth-1:0]  len_q, rd_issued_q, wr_issued_q, wr_rsp_q;
  logic [CntW-1:0]      rd_inflight_q, fifo_cnt_q;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [DataWidth-1:0] fifo_mem [FifoDepth];

  logic            start_ok, rd_hs, wr_hs, credit_ok, rsp_last;
  logic [CntW:0]   credit_sum;
  logic [LenWidth:0] rsp_next;

  assign start_ok   = (state_q == IDLE) && start_i && lock_ok_i;
  assign busy_o     = (state_q == COPY) || (state_q == DRAIN);
  assign done_o     = (state_q == DONE);

  // Reads in flight still own a FIFO slot, so the sum bounds occupancy.
  assign credit_sum = {1'b0, rd_inflight_q} + {1'b0, fifo_cnt_q};
  assign credit_ok  = credit_sum < DepthC;

  assign rd_req_o   = (state_q == COPY) && (rd_issued_q < len_q) && credit_ok;
  assign wr_req_o   = (state_q == COPY) && (fifo_cnt_q != '0);
  assign rd_hs      = rd_req_o && rd_gnt_i;
  assign wr_hs      = wr_req_o && wr_gnt_i;

  assign rd_addr_o  = src_q + AddrWidth'(rd_issued_q) * AddrWidth'(BeWidth);
  assign wr_addr_o  = dst_q + AddrWidth'(wr_issued_q) * AddrWidth'(BeWidth);
  assign wr_wdata_o = fifo_mem[rd_ptr_q];
  assign wr_be_o    = '1;

  // Count the response arriving this cycle so done follows the last rvalid by one cycle.
  assign rsp_next   = {1'b0, wr_rsp_q} + {{LenWidth{1'b0}}, wr_rvalid_i};
  assign rsp_last   = (rsp_next == {1'b0, len_q});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_ok) state_d = (len_i == '0) ? DONE : COPY;
      COPY:  if (wr_issued_q == len_q) state_d = rsp_last ? DONE : DRAIN;
      DRAIN: if (rsp_last) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      rd_issued_q   <= '0;
      wr_issued_q   <= '0;
      wr_rsp_q      <= '0;
      rd_inflight_q <= '0;
    end else if (start_ok) begin
      src_q         <= src_addr_i;
      dst_q         <= dst_addr_i;
      len_q         <= len_i;
      rd_issued_q   <= '0;
      wr_issued_q   <= '0;
      wr_rsp_q      <= '0;
      rd_inflight_q <= '0;
    end else begin
      if (rd_hs)                 rd_issued_q <= rd_issued_q + 1'b1;
      if (wr_hs)                 wr_issued_q <= wr_issued_q + 1'b1;
      if (wr_rvalid_i && busy_o) wr_rsp_q    <= wr_rsp_q + 1'b1;
      case ({rd_hs, rd_rvalid_i})
        2'b10:   rd_inflight_q <= rd_inflight_q + 1'b1;
        2'b01:   rd_inflight_q <= rd_inflight_q - 1'b1;
        default: rd_inflight_q <= rd_inflight_q;
      endcase
    end
  end

  // Registered FIFO, no fall-through: a pushed word is visible the next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FifoDepth; i++) fifo_mem[i] <= '0;
    end else begin
      if (rd_rvalid_i) begin
        fifo_mem[wr_ptr_q] <= rd_rdata_i;
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (wr_hs) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({rd_rvalid_i, wr_hs})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

`ifdef AXI_LLC_ARCANE_DMA_PERF_EN
  logic [31:0] cycles_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                            cycles_q <= '0;
    else if (start_ok)                    cycles_q <= '0;
    else if (busy_o && (cycles_q != '1))  cycles_q <= cycles_q + 1'b1;
  end
  assign cycles_o = cycles_q;
`endif

endmodule

// File: tb/tb_axi_llc_arcane_dma_ctl.sv
// Scoreboard bench for axi_llc_arcane_dma_ctl: stimulus pushes expected handshakes, a monitor pops and compares.
module tb_axi_llc_arcane_dma_ctl;
  logic        clk_i = 0;
  logic        rst_i;
  logic        lock_ok_i, start_i;
  logic [31:0] src_addr_i, dst_addr_i;
  logic [15:0] len_i;
  logic        busy_o, done_o;
  logic        rd_req_o, rd_gnt_i, rd_rvalid_i;
  logic [31:0] rd_addr_o, rd_rdata_i;
  logic        wr_req_o, wr_gnt_i, wr_rvalid_i;
  logic [31:0] wr_addr_o, wr_wdata_o;
  logic [3:0]  wr_be_o;
`ifdef AXI_LLC_ARCANE_DMA_PERF_EN
  logic [31:0] cycles_o;
`endif

  axi_llc_arcane_dma_ctl dut (
    .clk_i(clk_i), .rst_i(rst_i), .lock_ok_i(lock_ok_i), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o),
    .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i), .rd_addr_o(rd_addr_o),
    .rd_rvalid_i(rd_rvalid_i), .rd_rdata_i(rd_rdata_i),
    .wr_req_o(wr_req_o), .wr_gnt_i(wr_gnt_i), .wr_addr_o(wr_addr_o),
    .wr_wdata_o(wr_wdata_o), .wr_be_o(wr_be_o), .wr_rvalid_i(wr_rvalid_i)
`ifdef AXI_LLC_ARCANE_DMA_PERF_EN
    , .cycles_o(cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, rd_hs_cnt = 0, wr_hs_cnt = 0;
  logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory responder: answers each handshake exactly one cycle later.
  initial begin
    logic rd_pend, wr_pend;
    logic [31:0] rd_pend_addr;
    rd_pend = 0; wr_pend = 0; rd_pend_addr = 0;
    rd_rvalid_i = 0; rd_rdata_i = 0; wr_rvalid_i = 0;
    forever begin
      @(negedge clk_i); #1;
      if (rst_i) begin
        rd_pend = 0; wr_pend = 0;
        rd_rvalid_i = 0; rd_rdata_i = 0; wr_rvalid_i = 0;
      end else begin
        rd_rvalid_i  = rd_pend;
        rd_rdata_i   = rd_pend ? dat(rd_pend_addr) : 32'h0;
        wr_rvalid_i  = wr_pend;
        rd_pend      = rd_req_o & rd_gnt_i;
        rd_pend_addr = rd_addr_o;
        wr_pend      = wr_req_o & wr_gnt_i;
      end
    end
  end

  // Monitor: pops the scoreboard on every completed handshake.
  initial begin
    forever begin
      @(negedge clk_i); #2;
      if (!rst_i) begin
        if (rd_req_o && rd_gnt_i) begin
          rd_hs_cnt++;
          if (exp_rd.size() == 0) begin
            n_chk++;
            $display("FAIL rd_unexpected: got addr %0h want no read", rd_addr_o);
          end else chk("rd_addr", rd_addr_o, exp_rd.pop_front());
        end
        if (wr_req_o && wr_gnt_i) begin
          wr_hs_cnt++;
          if (exp_wa.size() == 0) begin
            n_chk++;
            $display("FAIL wr_unexpected: got addr %0h want no write", wr_addr_o);
          end else begin
            chk("wr_addr", wr_addr_o, exp_wa.pop_front());
            chk("wr_data", wr_wdata_o, exp_wd.pop_front());
            chk("wr_be", wr_be_o, 4'hF);
          end
        end
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                            input logic lk, output int c0);
    @(negedge clk_i);
    src_addr_i = s; dst_addr_i = d; len_i = l; lock_ok_i = lk; start_i = 1;
    c0 = cyc;
    @(negedge clk_i);
    start_i = 0;
  endtask

  task automatic wait_done(input int d0, input string name, output int bc);
    int i;
    bc = 0; i = 0;
    while (done_cnt == d0 && i < 300) begin
      if (busy_o) bc++;
      @(negedge clk_i); #3;
      i++;
    end
    if (done_cnt == d0) begin
      n_chk++;
      $display("FAIL %s_timeout: got no done want done within 300 cycles", name);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_busy"},  busy_o, 0);
    chk({name, "_done"},  done_o, 0);
    chk({name, "_rdreq"}, rd_req_o, 0);
    chk({name, "_wrreq"}, wr_req_o, 0);
    chk({name, "_rdaddr"}, rd_addr_o, 0);
    chk({name, "_wraddr"}, wr_addr_o, 0);
    chk({name, "_wdata"}, wr_wdata_o, 0);
    chk({name, "_be"},    wr_be_o, 4'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0, r0, w0, bc;
    logic [31:0] t1_rd [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    logic [31:0] t1_wa [4] = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
    logic [31:0] t1_wd [4] = '{32'hA5A51000, 32'hA5A51004, 32'hA5A51008, 32'hA5A5100C};
    logic [31:0] wp_rd [4] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
    logic [31:0] wp_wd [4] = '{32'h5A5AFFF8, 32'h5A5AFFFC, 32'hA5A50000, 32'hA5A50004};

    rst_i = 1; lock_ok_i = 0; start_i = 0; src_addr_i = 0; dst_addr_i = 0; len_i = 0;
    rd_gnt_i = 1; wr_gnt_i = 1;
    repeat (3) @(negedge clk_i);
    rst_i = 0;
    #3 chk_idle_outputs("reset");

    // len=4 basic copy, zero-wait grants
    for (int i = 0; i < 4; i++) begin
      exp_rd.push_back(t1_rd[i]); exp_wa.push_back(t1_wa[i]); exp_wd.push_back(t1_wd[i]);
    end
    d0 = done_cnt;
    start_xfer(32'h1000, 32'h2000, 16'd4, 1'b1, c0);
    #2 chk("len4_rdreq_n1", rd_req_o, 1);
    wait_done(d0, "len4", bc);
    chk("len4_done_lat", done_cyc - c0, 8);
    chk("len4_busy_cycles", bc, 7);
    repeat (3) @(negedge clk_i);
    #3 chk("len4_done_once", done_cnt - d0, 1);
    chk("len4_sb_empty", exp_rd.size() + exp_wa.size(), 0);

    // len=0 finishes at N+1 without traffic
    d0 = done_cnt; r0 = rd_hs_cnt; w0 = wr_hs_cnt;
    start_xfer(32'h3000, 32'h4000, 16'd0, 1'b1, c0);
    #2 chk("len0_done_n1", done_o, 1);
    chk("len0_rdreq", rd_req_o, 0);
    chk("len0_busy", busy_o, 0);
    repeat (3) @(negedge clk_i);
    #3 chk("len0_done_once", done_cnt - d0, 1);
    chk("len0_no_traffic", (rd_hs_cnt - r0) + (wr_hs_cnt - w0), 0);

    // start without lock is ignored
    d0 = done_cnt; r0 = rd_hs_cnt;
    start_xfer(32'h3000, 32'h4000, 16'd8, 1'b0, c0);
    #2 chk("nolock_busy", busy_o, 0);
    repeat (5) @(negedge clk_i);
    #3 chk("nolock_busy_later", busy_o, 0);
    chk("nolock_no_reads", rd_hs_cnt - r0, 0);
    chk("nolock_no_done", done_cnt - d0, 0);

    // len=16 with write grant held off: credits cap reads at FifoDepth
    for (int i = 0; i < 16; i++) begin
      exp_rd.push_back(32'h5000 + 32'(i) * 4);
      exp_wa.push_back(32'h6000 + 32'(i) * 4);
      exp_wd.push_back(dat(32'h5000 + 32'(i) * 4));
    end
    wr_gnt_i = 0;
    d0 = done_cnt; r0 = rd_hs_cnt; w0 = wr_hs_cnt;
    start_xfer(32'h5000, 32'h6000, 16'd16, 1'b1, c0);
    repeat (20) @(negedge clk_i);
    #3 chk("stall_reads", rd_hs_cnt - r0, 4);
    chk("stall_writes", wr_hs_cnt - w0, 0);
    chk("stall_rdreq", rd_req_o, 0);
    chk("stall_busy", busy_o, 1);
    @(negedge clk_i);
    wr_gnt_i = 1;
    wait_done(d0, "stall", bc);
    chk("stall_all_writes", wr_hs_cnt - w0, 16);
    chk("stall_sb_empty", exp_rd.size() + exp_wa.size(), 0);

    // source address wrap-around
    for (int i = 0; i < 4; i++) begin
      exp_rd.push_back(wp_rd[i]);
      exp_wa.push_back(32'h7000 + 32'(i) * 4);
      exp_wd.push_back(wp_wd[i]);
    end
    d0 = done_cnt;
    start_xfer(32'hFFFFFFF8, 32'h7000, 16'd4, 1'b1, c0);
    wait_done(d0, "wrap", bc);
    chk("wrap_sb_empty", exp_rd.size() + exp_wa.size(), 0);

    // reset mid-transfer after 3 of 8 writes
    for (int i = 0; i < 8; i++) begin
      exp_rd.push_back(32'h8000 + 32'(i) * 4);
      exp_wa.push_back(32'h9000 + 32'(i) * 4);
      exp_wd.push_back(dat(32'h8000 + 32'(i) * 4));
    end
    d0 = done_cnt; w0 = wr_hs_cnt;
    start_xfer(32'h8000, 32'h9000, 16'd8, 1'b1, c0);
    for (int i = 0; i < 100 && (wr_hs_cnt - w0) < 3; i++) begin
      @(negedge clk_i); #3;
    end
    chk("rstmid_reached3", (wr_hs_cnt - w0) >= 3, 1);
    rst_i = 1;
    #1 chk_idle_outputs("rstmid");
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    repeat (4) @(negedge clk_i);
    #3 chk("rstmid_no_done", done_cnt - d0, 0);
    chk("rstmid_idle", busy_o, 0);

    for (int i = 0; i < 2; i++) begin
      exp_rd.push_back(32'hA000 + 32'(i) * 4);
      exp_wa.push_back(32'hB000 + 32'(i) * 4);
      exp_wd.push_back(dat(32'hA000 + 32'(i) * 4));
    end
    d0 = done_cnt;
    start_xfer(32'hA000, 32'hB000, 16'd2, 1'b1, c0);
    wait_done(d0, "post_rst", bc);
    repeat (2) @(negedge clk_i);
    #3 chk("post_rst_done_once", done_cnt - d0, 1);
    chk("post_rst_sb_empty", exp_rd.size() + exp_wa.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
